// File: rtl/data_memory.sv
// data_memory: byte-addressed 64-bit data RAM with sized little-endian loads/stores,
// alignment checking and an optional zero-fill sweep after reset.
module data_memory #(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int DEPTH_WORDS    = 128
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  RAM_ADDR,
    input  logic [63:0] RAM_WRITE_DATA,
    input  logic        RAM_WRITE_ENABLE,
    input  logic [1:0]  RAM_ACCESS_SIZE,
    output logic [63:0] RAM_READ_DATA,
    output logic        MISALIGNED,
    output logic        BUSY
);
    typedef enum logic {CLEAR, READY} state_t;

    state_t      state;
    logic [6:0]  clear_index;
    logic [63:0] mem [DEPTH_WORDS];
    logic [6:0]  word_index;
    logic [5:0]  bit_off;
    logic        misaligned_now;
    logic        store_now;
    logic [7:0]  byte_mask;
    logic [63:0] size_mask;
    logic [63:0] wdata_sh;
    logic [63:0] merged_word;
    logic [63:0] load_data;

    assign BUSY = (state == CLEAR);

    // The read path sees the store merged in, giving write-first read-back.
    always_comb begin
        word_index     = RAM_ADDR[9:3];
        bit_off        = {RAM_ADDR[2:0], 3'b000};
        misaligned_now = |(RAM_ADDR[2:0] & ((RAM_ACCESS_SIZE == 2'd3) ? 3'd7 :
                                            (RAM_ACCESS_SIZE == 2'd2) ? 3'd3 :
                                            (RAM_ACCESS_SIZE == 2'd1) ? 3'd1 : 3'd0));
        size_mask      = (RAM_ACCESS_SIZE == 2'd3) ? 64'hFFFF_FFFF_FFFF_FFFF :
                         (RAM_ACCESS_SIZE == 2'd2) ? 64'h0000_0000_FFFF_FFFF :
                         (RAM_ACCESS_SIZE == 2'd1) ? 64'h0000_0000_0000_FFFF : 64'h0000_0000_0000_00FF;
        byte_mask      = ((RAM_ACCESS_SIZE == 2'd3) ? 8'hFF :
                          (RAM_ACCESS_SIZE == 2'd2) ? 8'h0F :
                          (RAM_ACCESS_SIZE == 2'd1) ? 8'h03 : 8'h01) << RAM_ADDR[2:0];
        store_now      = (state == READY) && RAM_WRITE_ENABLE && !misaligned_now;
        wdata_sh       = (RAM_WRITE_DATA & size_mask) << bit_off;
        merged_word    = mem[word_index];
        for (int b = 0; b < 8; b++)
            if (store_now && byte_mask[b])
                merged_word[8*b +: 8] = wdata_sh[8*b +: 8];
        load_data      = misaligned_now ? 64'h0 : (merged_word >> bit_off) & size_mask;
    end

    // The array has no reset term, so it is never touched asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= CLEAR_ON_RESET ? CLEAR : READY;
            clear_index   <= 7'd0;
            RAM_READ_DATA <= 64'h0;
            MISALIGNED    <= 1'b0;
        end else if (state == CLEAR) begin
            mem[clear_index] <= 64'h0;
            clear_index      <= clear_index + 7'd1;
            if (clear_index == 7'(DEPTH_WORDS - 1))
                state <= READY;
            RAM_READ_DATA    <= 64'h0;
            MISALIGNED       <= 1'b0;
        end else begin
            if (store_now)
                mem[word_index] <= merged_word;
            RAM_READ_DATA <= load_data;
            MISALIGNED    <= misaligned_now;
        end
    end
endmodule
